mem_stage_lsu: RTL and testbench
================================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width (multiple of 8, minimum 32).
REQ-002 SHALL have parameter XADDR, default 5, register-address width.
REQ-003 SHALL have parameter OPLEN, default 7, opcode width.
REQ-004 SHALL have parameter MAX_WAIT, default 15, maximum ack-wait cycles before the access is aborted (1..255).
REQ-005 i_clk  in  1  single clock; all state updates on rising edge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_valid  in  1  upstream instruction valid; i_opcode in OPLEN; i_funct3 in 3; i_rd_addr in XADDR; i_alu_result in XLEN (address or result); i_rs2_data in XLEN (store data); i_pc in XLEN.
REQ-008 o_ready  out  1  stage accepts the upstream instruction this cycle; o_stall out 1 equals ~o_ready.
REQ-009 o_dmem_req out 1; o_dmem_we out 1; o_dmem_addr out XLEN (word-aligned); o_dmem_wdata out XLEN; o_dmem_wstrb out XLEN/8; i_dmem_ack in 1; i_dmem_rdata in XLEN.
REQ-010 or_valid out 1; or_pc out XLEN; or_rd_addr out XADDR; or_alu_result out XLEN; or_mem_result out XLEN; or_opcode out OPLEN; or_fault out 1 (bus timeout); or_misalign out 1.

Function
REQ-011 FSM states IDLE, ACCESS; o_ready=1 only in IDLE.
REQ-012 IDLE, i_valid, opcode not LOAD (0000011) or STORE (0100011): register pc/rd/alu_result/opcode, or_valid=1 next cycle, or_mem_result=0; stay IDLE (1-cycle latency).
REQ-013 IDLE, i_valid, LOAD/STORE: capture address, funct3, store data, pc, rd, opcode; go ACCESS; or_valid=0 next cycle.
REQ-014 ACCESS: o_dmem_req=1; addr, we (1 for STORE), wdata, wstrb held stable until ack or abort.
REQ-015 ACCESS and i_dmem_ack: next cycle or_valid=1 for one cycle, return to IDLE; ack with req low is ignored.
REQ-016 Bus address = captured address with low log2(XLEN/8) bits cleared; byte offset = those low bits.
REQ-017 Store: SB wstrb one bit at offset, data byte replicated across lanes; SH two bits at offset, halfword replicated; SW all bits set; funct3 other values treated as SW.
REQ-018 Load: select lane(s) by offset; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; other funct3 treated as LW; store completes with or_mem_result=0.
REQ-019 Wait counter cleared entering ACCESS, increments each ACCESS cycle without ack; counter reaching MAX_WAIT without ack: drop req, or_valid=1, or_fault=1, or_mem_result=0, return IDLE.
REQ-020 Ack in the same cycle the counter reaches MAX_WAIT: ack wins, or_fault=0.
REQ-021 or_fault, or_misalign SHALL be 1 only in the or_valid cycle they qualify.
REQ-022 Every output register holds its value while or_valid=0, except or_valid, or_fault, or_misalign, which are 0.

Reset
REQ-023 i_rst=1 at a clock edge: state IDLE, counter 0, all or_* outputs 0, o_dmem_req=0, o_dmem_we=0, o_dmem_wstrb=0.
REQ-024 Reset during ACCESS SHALL abandon the access with no completion, or_valid=0; any later ack is ignored.

Configuration
REQ-025 Macro LSU_MISALIGN_TRAP_EN defined: halfword access with odd address or word access with non-zero offset issues no bus request; one cycle later or_valid=1, or_misalign=1, or_mem_result=0; stays IDLE.
REQ-026 Macro LSU_MISALIGN_TRAP_EN undefined: misalignment not checked, access proceeds using REQ-016..018 (halfword at offset 3 uses lane 3 plus zero-filled upper byte), or_misalign tied 0.

Verification
REQ-027 ADD, alu_result=0x1234, rd=5 -> next cycle or_valid=1, or_alu_result=0x1234, or_rd_addr=5, no dmem_req.
REQ-028 LB addr 0x103, rdata 0x80FF_0000 with ack after 2 wait cycles -> req 3 cycles at addr 0x100, or_mem_result=0xFFFF_FF80, o_stall high throughout.
REQ-029 SH addr 0x202, rs2=0xABCD_1234 -> wstrb=1100, wdata=0x1234_1234, we=1; ack -> or_valid=1, or_mem_result=0.
REQ-030 LW, no ack, MAX_WAIT=15 -> req drops after 15 cycles, or_fault=1 one cycle, next instruction accepted.
REQ-031 With LSU_MISALIGN_TRAP_EN: LW addr 0x101 -> no req, or_misalign=1 next cycle; without: LHU addr 0x102, rdata 0xBEEF_0000 -> or_mem_result=0x0000_BEEF.
REQ-032 i_rst asserted during ACCESS wait, ack 1 cycle after reset -> no or_valid, all outputs 0, o_ready=1.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory-stage load/store unit, one outstanding data-bus access with ack timeout
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of issuing them.
module mem_stage_lsu #(
  parameter int XLEN     = 32,
  parameter int XADDR    = 5,
  parameter int OPLEN    = 7,
  parameter int MAX_WAIT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [OPLEN-1:0]   i_opcode,
  input  logic [2:0]         i_funct3,
  input  logic [XADDR-1:0]   i_rd_addr,
  input  logic [XLEN-1:0]    i_alu_result,
  input  logic [XLEN-1:0]    i_rs2_data,
  input  logic [XLEN-1:0]    i_pc,
  output logic               o_ready,
  output logic               o_stall,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [XLEN-1:0]    o_dmem_addr,
  output logic [XLEN-1:0]    o_dmem_wdata,
  output logic [XLEN/8-1:0]  o_dmem_wstrb,
  input  logic               i_dmem_ack,
  input  logic [XLEN-1:0]    i_dmem_rdata,
  output logic               or_valid,
  output logic [XLEN-1:0]    or_pc,
  output logic [XADDR-1:0]   or_rd_addr,
  output logic [XLEN-1:0]    or_alu_result,
  output logic [XLEN-1:0]    or_mem_result,
  output logic [OPLEN-1:0]   or_opcode,
  output logic               or_fault,
  output logic               or_misalign
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam logic [OPLEN-1:0] OP_LOAD  = OPLEN'(7'b0000011);
  localparam logic [OPLEN-1:0] OP_STORE = OPLEN'(7'b0100011);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_cnt;
  logic [XLEN-1:0]   r_cap_pc, r_cap_alu;
  logic [XADDR-1:0]  r_cap_rd;
  logic [OPLEN-1:0]  r_cap_op;
  logic [2:0]        r_funct3;
  logic [OFFW-1:0]   r_off;
  logic              r_is_load;
  logic [XLEN-1:0]   r_dmem_addr, r_dmem_wdata;
  logic [NB-1:0]     r_dmem_wstrb;
  logic              r_dmem_we;

  logic              w_is_load, w_is_store, w_is_mem, w_misalign, w_timeout;
  logic [OFFW-1:0]   w_off;
  logic [XLEN-1:0]   w_st_wdata, w_ld_data, w_shift;
  logic [NB-1:0]     w_st_wstrb;

  assign w_is_load  = (i_opcode == OP_LOAD);
  assign w_is_store = (i_opcode == OP_STORE);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_off      = i_alu_result[OFFW-1:0];
  // Abort on the cycle the counter would reach MAX_WAIT; an ack in that same cycle still wins.
  assign w_timeout  = (r_cnt == 8'(MAX_WAIT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_half, w_word;
  always_comb begin
    w_half = 1'b0;
    w_word = 1'b0;
    if (w_is_store) begin
      w_half = (i_funct3 == 3'b001);
      w_word = (i_funct3 != 3'b000) && (i_funct3 != 3'b001);
    end else begin
      w_half = (i_funct3[1:0] == 2'b01);
      w_word = i_funct3[1];
    end
  end
  assign w_misalign = w_is_mem & ((w_half & w_off[0]) | (w_word & (|w_off)));
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_st_wdata = i_rs2_data;
    w_st_wstrb = '1;
    case (i_funct3)
      3'b000: begin
        w_st_wdata = {NB{i_rs2_data[7:0]}};
        w_st_wstrb = NB'(1) << w_off;
      end
      3'b001: begin
        w_st_wdata = {(NB/2){i_rs2_data[15:0]}};
        w_st_wstrb = NB'(3) << w_off;
      end
      default: ;
    endcase
  end

  // Shifting the lane down zero-fills, so a halfword at the top lane gets a zero upper byte.
  assign w_shift = i_dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = i_dmem_rdata;
    case (r_funct3)
      3'b000: w_ld_data = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
      3'b100: w_ld_data = {{(XLEN-8){1'b0}}, w_shift[7:0]};
      3'b001: w_ld_data = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      3'b101: w_ld_data = {{(XLEN-16){1'b0}}, w_shift[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_ready    = 1'b0;
    o_dmem_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid && w_is_mem && !w_misalign) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        o_dmem_req = 1'b1;
        if (i_dmem_ack || w_timeout) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_stall      = ~o_ready;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_dmem_we    = o_dmem_req & r_dmem_we;
  assign o_dmem_wstrb = (o_dmem_req & r_dmem_we) ? r_dmem_wstrb : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= '0;
      r_cap_pc      <= '0;
      r_cap_alu     <= '0;
      r_cap_rd      <= '0;
      r_cap_op      <= '0;
      r_funct3      <= '0;
      r_off         <= '0;
      r_is_load     <= 1'b0;
      r_dmem_addr   <= '0;
      r_dmem_wdata  <= '0;
      r_dmem_wstrb  <= '0;
      r_dmem_we     <= 1'b0;
      or_valid      <= 1'b0;
      or_pc         <= '0;
      or_rd_addr    <= '0;
      or_alu_result <= '0;
      or_mem_result <= '0;
      or_opcode     <= '0;
      or_fault      <= 1'b0;
      or_misalign   <= 1'b0;
    end else begin
      or_valid    <= 1'b0;
      or_fault    <= 1'b0;
      or_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            if (w_is_mem && !w_misalign) begin
              r_cap_pc     <= i_pc;
              r_cap_alu    <= i_alu_result;
              r_cap_rd     <= i_rd_addr;
              r_cap_op     <= i_opcode;
              r_funct3     <= i_funct3;
              r_off        <= w_off;
              r_is_load    <= w_is_load;
              r_dmem_addr  <= {i_alu_result[XLEN-1:OFFW], {OFFW{1'b0}}};
              r_dmem_wdata <= w_st_wdata;
              r_dmem_wstrb <= w_st_wstrb;
              r_dmem_we    <= w_is_store;
              r_cnt        <= '0;
            end else begin
              or_valid      <= 1'b1;
              or_pc         <= i_pc;
              or_rd_addr    <= i_rd_addr;
              or_alu_result <= i_alu_result;
              or_opcode     <= i_opcode;
              or_mem_result <= '0;
              or_misalign   <= w_misalign;
            end
          end
        end
        S_ACCESS: begin
          if (i_dmem_ack || w_timeout) begin
            or_valid      <= 1'b1;
            or_pc         <= r_cap_pc;
            or_rd_addr    <= r_cap_rd;
            or_alu_result <= r_cap_alu;
            or_opcode     <= r_cap_op;
            or_fault      <= ~i_dmem_ack;
            or_mem_result <= (i_dmem_ack && r_is_load) ? w_ld_data : '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu
module tb_mem_stage_lsu;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_alu_result, i_rs2_data, i_pc;
  logic        o_ready, o_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_wstrb;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        or_valid, or_fault, or_misalign;
  logic [31:0] or_pc, or_alu_result, or_mem_result;
  logic [4:0]  or_rd_addr;
  logic [6:0]  or_opcode;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [6:0]  op;
    logic        fault;
    logic        mis;
  } out_t;

  out_t sb[$];
  out_t w_obs, exp_o;
  int   checks = 0;
  int   failures = 0;

  assign w_obs = {or_pc, or_rd_addr, or_alu_result, or_mem_result, or_opcode, or_fault, or_misalign};

  mem_stage_lsu #(.XLEN(32), .XADDR(5), .OPLEN(7), .MAX_WAIT(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_rd_addr(i_rd_addr), .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data), .i_pc(i_pc),
    .o_ready(o_ready), .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .or_valid(or_valid), .or_pc(or_pc), .or_rd_addr(or_rd_addr), .or_alu_result(or_alu_result),
    .or_mem_result(or_mem_result), .or_opcode(or_opcode), .or_fault(or_fault), .or_misalign(or_misalign)
  );

  always #5 clk = ~clk;

  function automatic out_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] alu,
                              input logic [31:0] mem, input logic [6:0] op, input logic fault, input logic mis);
    out_t o;
    o.pc = pc; o.rd = rd; o.alu = alu; o.mem = mem; o.op = op; o.fault = fault; o.mis = mis;
    return o;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    logic [7:0] b [0:4];
    for (int i = 0; i < 4; i++) b[i] = rdata[8*i +: 8];
    b[4] = 8'h00;
    case (f3)
      3'b000:  return {{24{b[off][7]}}, b[off]};
      3'b100:  return {24'h0, b[off]};
      3'b001:  return {{16{b[off+1][7]}}, b[off+1], b[off]};
      3'b101:  return {16'h0, b[off+1], b[off]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic model_mis(input logic is_store, input logic [2:0] f3, input int off);
`ifdef LSU_MISALIGN_TRAP_EN
    int sz;
    if (is_store) sz = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    else          sz = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    return (sz == 2 && off[0]) || (sz == 4 && off != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic mem_access(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] pc,
                            input logic [31:0] rdata, input int ack_after,
                            output int req_cyc, output logic [31:0] s_addr, output logic [31:0] s_wdata,
                            output logic [3:0] s_wstrb, output logic s_we, output logic stable_ok,
                            output logic got_valid);
    req_cyc = 0; s_addr = '0; s_wdata = '0; s_wstrb = '0; s_we = 1'b0; stable_ok = 1'b1; got_valid = 1'b0;
    i_valid = 1'b1; i_opcode = op; i_funct3 = f3; i_rd_addr = rd;
    i_alu_result = addr; i_rs2_data = rs2; i_pc = pc;
    @(negedge clk);
    i_valid = 1'b0; i_alu_result = $urandom; i_rs2_data = $urandom; i_pc = $urandom;
    for (int c = 0; c < 64; c++) begin
      if (!o_dmem_req) begin
        got_valid = or_valid;
        break;
      end
      req_cyc++;
      if (req_cyc == 1) begin
        s_addr = o_dmem_addr; s_wdata = o_dmem_wdata; s_wstrb = o_dmem_wstrb; s_we = o_dmem_we;
      end
      if (o_stall !== 1'b1 || o_dmem_addr !== s_addr || o_dmem_wdata !== s_wdata ||
          o_dmem_wstrb !== s_wstrb || o_dmem_we !== s_we) stable_ok = 1'b0;
      if (ack_after >= 0 && req_cyc == ack_after + 1) begin
        i_dmem_ack = 1'b1; i_dmem_rdata = rdata;
      end else begin
        i_dmem_ack = 1'b0; i_dmem_rdata = $urandom;
      end
      @(negedge clk);
    end
    i_dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b1; i_opcode = OP_LOAD; i_alu_result = 32'h55; i_dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; i_valid = 1'b0; i_dmem_ack = 1'b0;
    checks++; if (or_valid !== 1'b0) begin failures++; $display("FAIL reset_or_valid got=%b exp=0", or_valid); end
    checks++; if (w_obs !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", w_obs); end
    checks++; if (o_dmem_req !== 1'b0 || o_dmem_we !== 1'b0 || o_dmem_wstrb !== 4'h0) begin
      failures++; $display("FAIL reset_bus got=%b%b%h exp=000", o_dmem_req, o_dmem_we, o_dmem_wstrb); end
    checks++; if (o_ready !== 1'b1 || o_stall !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%b/%b exp=1/0", o_ready, o_stall); end
  endtask

  task automatic test_alu();
    sb.push_back(mk(32'h40, 5'd5, 32'h1234, 32'h0, OP_ALU, 1'b0, 1'b0));
    i_valid = 1'b1; i_opcode = OP_ALU; i_funct3 = 3'b000; i_rd_addr = 5'd5;
    i_alu_result = 32'h1234; i_rs2_data = 32'hDEAD; i_pc = 32'h40;
    @(negedge clk);
    i_valid = 1'b0; i_alu_result = 32'hFFFF;
    exp_o = sb.pop_front();
    checks++; if (or_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b exp=1", or_valid); end
    checks++; if (o_dmem_req !== 1'b0) begin failures++; $display("FAIL alu_no_req got=%b exp=0", o_dmem_req); end
    checks++; if (w_obs !== exp_o) begin failures++; $display("FAIL alu_out got=%h exp=%h", w_obs, exp_o); end
    @(negedge clk);
    checks++; if (or_valid !== 1'b0 || or_alu_result !== 32'h1234) begin
      failures++; $display("FAIL alu_hold got=%b/%h exp=0/00001234", or_valid, or_alu_result); end
  endtask

  task automatic test_ignored_ack();
    i_dmem_ack = 1'b1;
    repeat (2) @(negedge clk);
    i_dmem_ack = 1'b0;
    checks++; if (or_valid !== 1'b0 || o_dmem_req !== 1'b0) begin
      failures++; $display("FAIL idle_ack got=%b/%b exp=0/0", or_valid, o_dmem_req); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] a = $urandom;
      sb.push_back(mk(32'h500 + 32'(4*k), 5'(k + 9), a, 32'h0, OP_IMM, 1'b0, 1'b0));
      i_valid = 1'b1; i_opcode = OP_IMM; i_rd_addr = 5'(k + 9); i_alu_result = a; i_pc = 32'h500 + 32'(4*k);
      checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%b exp=1", k, o_ready); end
      @(negedge clk);
      exp_o = sb.pop_front();
      checks++; if (or_valid !== 1'b1 || w_obs !== exp_o) begin
        failures++; $display("FAIL b2b_out%0d got=%b/%h exp=1/%h", k, or_valid, w_obs, exp_o); end
    end
    i_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_byte();
    int rc; logic [31:0] sa, sw; logic [3:0] ss; logic swe, st, gv;
    sb.push_back(mk(32'h80, 5'd7, 32'h103, 32'hFFFF_FF80, OP_LOAD, 1'b0, 1'b0));
    mem_access(OP_LOAD, 3'b000, 5'd7, 32'h103, 32'h0, 32'h80, 32'h80FF_0000, 2, rc, sa, sw, ss, swe, st, gv);
    exp_o = sb.pop_front();
    checks++; if (rc !== 3) begin failures++; $display("FAIL lb_req_cycles got=%0d exp=3", rc); end
    checks++; if (sa !== 32'h100 || swe !== 1'b0) begin failures++; $display("FAIL lb_bus got=%h/%b exp=00000100/0", sa, swe); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL lb_stall_stable got=%b exp=1", st); end
    checks++; if (gv !== 1'b1 || w_obs !== exp_o) begin failures++; $display("FAIL lb_out got=%b/%h exp=1/%h", gv, w_obs, exp_o); end
  endtask

  task automatic test_store_half();
    int rc; logic [31:0] sa, sw; logic [3:0] ss; logic swe, st, gv;
    sb.push_back(mk(32'h84, 5'd3, 32'h202, 32'h0, OP_STORE, 1'b0, 1'b0));
    mem_access(OP_STORE, 3'b001, 5'd3, 32'h202, 32'hABCD_1234, 32'h84, 32'hFFFF_FFFF, 0, rc, sa, sw, ss, swe, st, gv);
    exp_o = sb.pop_front();
    checks++; if (ss !== 4'b1100 || sw !== 32'h1234_1234 || swe !== 1'b1 || sa !== 32'h200) begin
      failures++; $display("FAIL sh_bus got=%b/%h/%b/%h exp=1100/12341234/1/00000200", ss, sw, swe, sa); end
    checks++; if (gv !== 1'b1 || w_obs !== exp_o) begin failures++; $display("FAIL sh_out got=%b/%h exp=1/%h", gv, w_obs, exp_o); end
  endtask

  task automatic test_timeout();
    int rc; logic [31:0] sa, sw; logic [3:0] ss; logic swe, st, gv;
    sb.push_back(mk(32'h88, 5'd4, 32'h300, 32'h0, OP_LOAD, 1'b1, 1'b0));
    mem_access(OP_LOAD, 3'b010, 5'd4, 32'h300, 32'h0, 32'h88, 32'h0, -1, rc, sa, sw, ss, swe, st, gv);
    exp_o = sb.pop_front();
    checks++; if (rc !== 15) begin failures++; $display("FAIL to_req_cycles got=%0d exp=15", rc); end
    checks++; if (gv !== 1'b1 || w_obs !== exp_o) begin failures++; $display("FAIL to_out got=%b/%h exp=1/%h", gv, w_obs, exp_o); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL to_ready got=%b exp=1", o_ready); end
    sb.push_back(mk(32'h8C, 5'd6, 32'h77, 32'h0, OP_ALU, 1'b0, 1'b0));
    i_valid = 1'b1; i_opcode = OP_ALU; i_rd_addr = 5'd6; i_alu_result = 32'h77; i_pc = 32'h8C;
    @(negedge clk);
    i_valid = 1'b0;
    exp_o = sb.pop_front();
    checks++; if (or_valid !== 1'b1 || w_obs !== exp_o) begin
      failures++; $display("FAIL to_next got=%b/%h exp=1/%h", or_valid, w_obs, exp_o); end
  endtask

  task automatic test_ack_at_limit();
    int rc; logic [31:0] sa, sw; logic [3:0] ss; logic swe, st, gv;
    sb.push_back(mk(32'h90, 5'd8, 32'h404, 32'hCAFE_F00D, OP_LOAD, 1'b0, 1'b0));
    mem_access(OP_LOAD, 3'b010, 5'd8, 32'h404, 32'h0, 32'h90, 32'hCAFE_F00D, 14, rc, sa, sw, ss, swe, st, gv);
    exp_o = sb.pop_front();
    checks++; if (rc !== 15) begin failures++; $display("FAIL lim_req_cycles got=%0d exp=15", rc); end
    checks++; if (gv !== 1'b1 || w_obs !== exp_o) begin failures++; $display("FAIL lim_out got=%b/%h exp=1/%h", gv, w_obs, exp_o); end
  endtask

  task automatic test_misalign_cfg();
    int rc; logic [31:0] sa, sw; logic [3:0] ss; logic swe, st, gv;
`ifdef LSU_MISALIGN_TRAP_EN
    sb.push_back(mk(32'h94, 5'd2, 32'h101, 32'h0, OP_LOAD, 1'b0, 1'b1));
    mem_access(OP_LOAD, 3'b010, 5'd2, 32'h101, 32'h0, 32'h94, 32'h1111_1111, 0, rc, sa, sw, ss, swe, st, gv);
    exp_o = sb.pop_front();
    checks++; if (rc !== 0) begin failures++; $display("FAIL mis_req_cycles got=%0d exp=0", rc); end
`else
    sb.push_back(mk(32'h94, 5'd2, 32'h102, 32'h0000_BEEF, OP_LOAD, 1'b0, 1'b0));
    mem_access(OP_LOAD, 3'b101, 5'd2, 32'h102, 32'h0, 32'h94, 32'hBEEF_0000, 0, rc, sa, sw, ss, swe, st, gv);
    exp_o = sb.pop_front();
    checks++; if (rc !== 1) begin failures++; $display("FAIL lhu_req_cycles got=%0d exp=1", rc); end
`endif
    checks++; if (gv !== 1'b1 || w_obs !== exp_o) begin failures++; $display("FAIL cfg_out got=%b/%h exp=1/%h", gv, w_obs, exp_o); end
    @(negedge clk);
    checks++; if (or_valid !== 1'b0 || or_misalign !== 1'b0) begin
      failures++; $display("FAIL cfg_pulse got=%b/%b exp=0/0", or_valid, or_misalign); end
  endtask

  task automatic test_load_variants();
    logic [2:0] f3s [0:5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110};
    int rc; logic [31:0] sa, sw; logic [3:0] ss; logic swe, st, gv;
    for (int i = 0; i < 6; i++) begin
      for (int off = 0; off < 4; off++) begin
        logic [31:0] rdata = $urandom;
        logic [31:0] addr = 32'h600 + 32'(16*i + off);
        logic mis = model_mis(1'b0, f3s[i], off);
        sb.push_back(mk(addr ^ 32'hF000, 5'(i + off), addr, mis ? 32'h0 : model_load(f3s[i], off, rdata),
                        OP_LOAD, 1'b0, mis));
        mem_access(OP_LOAD, f3s[i], 5'(i + off), addr, 32'h0, addr ^ 32'hF000, rdata, 0, rc, sa, sw, ss, swe, st, gv);
        exp_o = sb.pop_front();
        checks++; if (rc !== (mis ? 0 : 1) || (!mis && sa !== (addr & ~32'h3))) begin
          failures++; $display("FAIL ld_bus f3=%0d off=%0d got=%0d/%h exp=%0d/%h", f3s[i], off, rc, sa, mis ? 0 : 1, addr & ~32'h3); end
        checks++; if (gv !== 1'b1 || w_obs !== exp_o) begin
          failures++; $display("FAIL ld_out f3=%0d off=%0d got=%b/%h exp=1/%h", f3s[i], off, gv, w_obs, exp_o); end
      end
    end
  endtask

  task automatic test_store_variants();
    logic [2:0] f3s [0:3] = '{3'b000, 3'b001, 3'b010, 3'b111};
    int rc; logic [31:0] sa, sw; logic [3:0] ss; logic swe, st, gv;
    for (int i = 0; i < 4; i++) begin
      for (int off = 0; off < 4; off++) begin
        logic [31:0] rs2 = $urandom;
        logic [31:0] addr = 32'h700 + 32'(16*i + off);
        logic mis = model_mis(1'b1, f3s[i], off);
        logic [3:0] e_strb;
        logic [31:0] e_data;
        if (f3s[i] == 3'b000) begin e_strb = 4'b0001 << off; e_data = {4{rs2[7:0]}}; end
        else if (f3s[i] == 3'b001) begin e_strb = 4'b0011 << off; e_data = {2{rs2[15:0]}}; end
        else begin e_strb = 4'b1111; e_data = rs2; end
        sb.push_back(mk(addr, 5'd1, addr, 32'h0, OP_STORE, 1'b0, mis));
        mem_access(OP_STORE, f3s[i], 5'd1, addr, rs2, addr, $urandom, 1, rc, sa, sw, ss, swe, st, gv);
        exp_o = sb.pop_front();
        if (!mis) begin
          checks++; if (ss !== e_strb || sw !== e_data || swe !== 1'b1 || st !== 1'b1) begin
            failures++; $display("FAIL st_bus f3=%0d off=%0d got=%b/%h/%b/%b exp=%b/%h/1/1", f3s[i], off, ss, sw, swe, st, e_strb, e_data); end
        end
        checks++; if (gv !== 1'b1 || w_obs !== exp_o) begin
          failures++; $display("FAIL st_out f3=%0d off=%0d got=%b/%h exp=1/%h", f3s[i], off, gv, w_obs, exp_o); end
      end
    end
  endtask

  task automatic test_reset_in_access();
    i_valid = 1'b1; i_opcode = OP_LOAD; i_funct3 = 3'b010; i_rd_addr = 5'd12;
    i_alu_result = 32'h800; i_pc = 32'hA0;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_dmem_req !== 1'b1 || o_ready !== 1'b0) begin
      failures++; $display("FAIL rsta_req got=%b/%b exp=1/0", o_dmem_req, o_ready); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_dmem_ack = 1'b1; i_dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    i_dmem_ack = 1'b0;
    checks++; if (or_valid !== 1'b0 || w_obs !== '0) begin
      failures++; $display("FAIL rsta_out got=%b/%h exp=0/0", or_valid, w_obs); end
    checks++; if (o_ready !== 1'b1 || o_dmem_req !== 1'b0 || o_dmem_we !== 1'b0 || o_dmem_wstrb !== 4'h0) begin
      failures++; $display("FAIL rsta_bus got=%b/%b/%b/%h exp=1/0/0/0", o_ready, o_dmem_req, o_dmem_we, o_dmem_wstrb); end
    @(negedge clk);
    checks++; if (or_valid !== 1'b0) begin failures++; $display("FAIL rsta_late got=%b exp=0", or_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_opcode = '0; i_funct3 = '0; i_rd_addr = '0;
    i_alu_result = '0; i_rs2_data = '0; i_pc = '0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_ignored_ack();
    test_back_to_back();
    test_load_byte();
    test_store_half();
    test_timeout();
    test_ack_at_limit();
    test_misalign_cfg();
    test_load_variants();
    test_store_variants();
    test_reset_in_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
